// File: rtl/shift_operator_r_seq.sv
// -----------------------------------------------------------------------------
// shift_operator_r_seq
//
// Sequential right shifter for the ALU datapath. Shifts an N-bit operand right
// by a programmable amount, one bit position per clock, in either logical
// (zero-fill) or arithmetic (sign-fill) mode. The ALU controller drives it
// through a start/busy/done handshake.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous, active-high reset (highest priority)
//   start   in   1   request pulse, accepted only when not shifting
//   A       in   N   operand, sampled when start is accepted
//   bshift  in   SW  shift amount (0 .. 2^SW-1), sampled with A
//   arith   in   1   1 = arithmetic (fill with A[N-1]), 0 = logical (fill 0)
//   busy    out  1   high while shifting is in progress
//   done    out  1   one-cycle pulse, y is valid in that cycle
//   y       out  N   registered result, held until the next done
// -----------------------------------------------------------------------------
module shift_operator_r_seq #(
    parameter int N  = 5,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] bshift,
    input  logic          arith,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  sreg;
    logic [SW-1:0] cnt;
    logic          fill;
    logic          accept;
    logic [N-1:0]  sreg_shifted;

    // A request is taken in IDLE and also in DONE, which allows back-to-back
    // operation without an idle gap. Requests during SHIFT are dropped.
    assign accept       = start && (state != SHIFT);
    assign sreg_shifted = {fill, sreg[N-1:1]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bshift == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == SW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = (bshift == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, remaining count, fill bit and result
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
            fill <= 1'b0;
            y    <= '0;
        end else if (accept) begin
            sreg <= A;
            cnt  <= bshift;
            // Fill bit is frozen here so a later change of arith or A cannot
            // corrupt an operation already in flight.
            fill <= arith & A[N-1];
            // Zero-length shift goes straight to DONE with the operand itself.
            if (bshift == '0) begin
                y <= A;
            end
        end else if (state == SHIFT) begin
            sreg <= sreg_shifted;
            cnt  <= cnt - SW'(1);
            // Last step: publish the result on the edge entering DONE.
            if (cnt == SW'(1)) begin
                y <= sreg_shifted;
            end
        end
    end

endmodule

// File: tb/tb_shift_operator_r_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_operator_r_seq
//
// Directed self-checking bench for shift_operator_r_seq (N=5, SW=2).
// Inputs are driven 1 ns after a rising edge so they are stable for the next
// edge; outputs are sampled at the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_shift_operator_r_seq;

    localparam int N  = 5;
    localparam int SW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [N-1:0]  A;
    logic [SW-1:0] bshift;
    logic          arith;
    logic          busy;
    logic          done;
    logic [N-1:0]  y;

    int checks;
    int errors;

    shift_operator_r_seq #(
        .N  (N),
        .SW (SW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .bshift (bshift),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Checks busy, done and y together.
    task automatic check_out(input string tag, input logic exp_busy,
                             input logic exp_done, input logic [N-1:0] exp_y);
        check({tag, ".busy"}, 8'(busy), 8'(exp_busy));
        check({tag, ".done"}, 8'(done), 8'(exp_done));
        check({tag, ".y"},    8'(y),    8'(exp_y));
    endtask

    task automatic request(input logic [N-1:0] a_v, input logic [SW-1:0] s_v,
                           input logic ar_v);
        start  = 1'b1;
        A      = a_v;
        bshift = s_v;
        arith  = ar_v;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        A      = '0;
        bshift = '0;
        arith  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 5'b00000);
        reset = 1'b0;
        tick();
        check_out("idle_after_reset", 1'b0, 1'b0, 5'b00000);

        // ---------------- logical shift by 2 ----------------
        request(5'b10110, 2'd2, 1'b0);
        tick();                                     // edge k: accepted
        start = 1'b0;
        check_out("lsr2_busy1", 1'b1, 1'b0, 5'b00000);
        tick();
        check_out("lsr2_busy2", 1'b1, 1'b0, 5'b00000);
        tick();                                     // edge k+2
        check_out("lsr2_done", 1'b0, 1'b1, 5'b00101);
        tick();
        check_out("lsr2_idle", 1'b0, 1'b0, 5'b00101);

        // ---------------- arithmetic shift by 2 ----------------
        request(5'b10110, 2'd2, 1'b1);
        tick();
        start = 1'b0;
        check_out("asr2_busy1", 1'b1, 1'b0, 5'b00101);
        tick();
        check_out("asr2_busy2", 1'b1, 1'b0, 5'b00101);
        tick();
        check_out("asr2_done", 1'b0, 1'b1, 5'b11101);
        tick();
        check_out("asr2_idle", 1'b0, 1'b0, 5'b11101);

        // ---------------- arithmetic shift by 3 (max) ----------------
        request(5'b10000, 2'd3, 1'b1);
        tick();
        start = 1'b0;
        check_out("asr3_busy1", 1'b1, 1'b0, 5'b11101);
        tick();
        check_out("asr3_busy2", 1'b1, 1'b0, 5'b11101);
        tick();
        check_out("asr3_busy3", 1'b1, 1'b0, 5'b11101);
        tick();
        check_out("asr3_done", 1'b0, 1'b1, 5'b11110);
        tick();
        check_out("asr3_idle", 1'b0, 1'b0, 5'b11110);

        // ---------------- zero shift ----------------
        request(5'b01011, 2'd0, 1'b1);
        tick();
        start = 1'b0;
        check_out("zero_done", 1'b0, 1'b1, 5'b01011);
        tick();
        check_out("zero_idle", 1'b0, 1'b0, 5'b01011);

        // ---------------- start while busy is ignored ----------------
        request(5'b11111, 2'd3, 1'b0);
        tick();
        check_out("ign_busy1", 1'b1, 1'b0, 5'b01011);
        request(5'b00001, 2'd1, 1'b0);              // must be dropped
        tick();
        start = 1'b0;
        check_out("ign_busy2", 1'b1, 1'b0, 5'b01011);
        tick();
        check_out("ign_busy3", 1'b1, 1'b0, 5'b01011);
        tick();
        check_out("ign_done", 1'b0, 1'b1, 5'b00011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("ign_no_second_done", 1'b0, 1'b0, 5'b00011);
        end

        // ---------------- back-to-back from DONE ----------------
        request(5'b10110, 2'd1, 1'b0);
        tick();
        start = 1'b0;
        check_out("b2b_first_busy", 1'b1, 1'b0, 5'b00011);
        tick();
        check_out("b2b_first_done", 1'b0, 1'b1, 5'b01011);
        request(5'b01000, 2'd1, 1'b0);              // issued in the DONE cycle
        tick();
        start = 1'b0;
        check_out("b2b_second_busy", 1'b1, 1'b0, 5'b01011);
        tick();
        check_out("b2b_second_done", 1'b0, 1'b1, 5'b00100);
        tick();
        check_out("b2b_idle", 1'b0, 1'b0, 5'b00100);

        // ---------------- reset mid-shift ----------------
        request(5'b10101, 2'd3, 1'b1);
        tick();
        start = 1'b0;
        check_out("rst_busy1", 1'b1, 1'b0, 5'b00100);
        tick();
        check_out("rst_busy2", 1'b1, 1'b0, 5'b00100);
        reset = 1'b1;                               // asserted on 2nd busy cycle
        tick();
        reset = 1'b0;
        check_out("rst_abort", 1'b0, 1'b0, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("rst_no_done", 1'b0, 1'b0, 5'b00000);
        end

        // ---------------- reset has priority over start ----------------
        request(5'b11100, 2'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_out("rst_prio", 1'b0, 1'b0, 5'b00000);
        tick();
        check_out("rst_prio_after", 1'b0, 1'b0, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
